// File: rtl/gmii_rx_frame_parser.sv
// GMII receive framer: strips preamble/SFD, packs 10/100 nibbles, enforces length limits.
// Define RX_FCS_CHECK_EN to add CRC-32 checking of the received FCS.
module gmii_rx_frame_parser #(
    parameter int unsigned MAX_FRAME_LEN = 1518,
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             rx_clk,
    input  logic             rx_reset,
    input  logic             speed_10_100,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_last,
    output logic             rx_err,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad
);

    localparam int unsigned LEN_W = $clog2(MAX_FRAME_LEN + 2);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_nib_mode;
    logic             r_nib_phase;
    logic [3:0]       r_nib_lo;
    logic [7:0]       r_hold;
    logic             r_hold_vld;
    logic [LEN_W-1:0] r_len;
    logic             r_err_seen;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_last;
    logic             r_rx_err;
    logic [CNT_W-1:0] r_frames_ok;
    logic [CNT_W-1:0] r_frames_bad;

    logic             w_mode;
    logic             w_is_pre;
    logic             w_is_sfd;
    logic [7:0]       w_byte;
    logic             w_byte_done;
    logic             w_over;
    logic             w_end;
    logic             w_fcs_bad;
    logic             w_frame_err;
    logic             w_emit;
    logic             w_last;

    // In IDLE the mode is not yet latched, so decode with the live pin.
    assign w_mode      = (r_state == IDLE) ? speed_10_100 : r_nib_mode;
    assign w_is_pre    = w_mode ? (gmii_rxd[3:0] == 4'h5) : (gmii_rxd == 8'h55);
    assign w_is_sfd    = w_mode ? (gmii_rxd[3:0] == 4'hD) : (gmii_rxd == 8'hD5);
    assign w_byte      = r_nib_mode ? {gmii_rxd[3:0], r_nib_lo} : gmii_rxd;
    assign w_byte_done = (r_state == DATA) && gmii_rx_dv && (!r_nib_mode || r_nib_phase);
    assign w_over      = w_byte_done && (r_len == LEN_W'(MAX_FRAME_LEN));
    assign w_end       = (r_state == DATA) && !gmii_rx_dv;

`ifdef RX_FCS_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_rev;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c;
        for (int unsigned i = 0; i < 8; i++) begin
            x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    always_ff @(posedge rx_clk) begin
        if (rx_reset || r_state != DATA) begin
            r_crc <= '1;
        end else if (w_byte_done) begin
            r_crc <= crc32_byte(r_crc, w_byte);
        end
    end

    // Register is reflected; its bit-reversal is compared to the normal-order residue.
    assign w_crc_rev = {<<{r_crc}};
    assign w_fcs_bad = (w_crc_rev != 32'hC704DD7B);
`else
    assign w_fcs_bad = 1'b0;
`endif

    always_ff @(posedge rx_clk) begin
        if (rx_reset) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (gmii_rx_dv) w_next_state = w_is_pre ? PREAMBLE : DROP;
            PREAMBLE: begin
                if (!gmii_rx_dv)     w_next_state = IDLE;
                else if (gmii_rx_er) w_next_state = DROP;
                else if (w_is_sfd)   w_next_state = DATA;
                else if (!w_is_pre)  w_next_state = DROP;
            end
            DATA: begin
                if (!gmii_rx_dv)     w_next_state = IDLE;
                else if (w_over)     w_next_state = DROP;
            end
            DROP:     if (!gmii_rx_dv) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_last      = w_end || w_over;
        w_frame_err = w_over || r_err_seen || r_nib_phase || w_fcs_bad ||
                      (r_len == '0) ||
                      (r_len < LEN_W'(MIN_FRAME_LEN)) ||
                      (r_len > LEN_W'(MAX_FRAME_LEN));
        // Held byte leaves only once its successor completes or the frame ends.
        w_emit      = r_hold_vld && (w_byte_done || w_end);
    end

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            r_nib_mode   <= 1'b0;
            r_nib_phase  <= 1'b0;
            r_nib_lo     <= '0;
            r_hold       <= '0;
            r_hold_vld   <= 1'b0;
            r_len        <= '0;
            r_err_seen   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_last    <= 1'b0;
            r_rx_err     <= 1'b0;
            r_frames_ok  <= '0;
            r_frames_bad <= '0;
        end else begin
            r_rx_valid <= w_emit;
            r_rx_last  <= w_emit && w_last;
            r_rx_err   <= w_emit && w_last && w_frame_err;
            if (w_emit) r_rx_data <= r_hold;

            if (w_last) begin
                if (w_frame_err) r_frames_bad <= r_frames_bad + CNT_W'(1);
                else             r_frames_ok  <= r_frames_ok + CNT_W'(1);
            end

            if (r_state == IDLE && w_next_state == PREAMBLE) r_nib_mode <= speed_10_100;

            if (r_state != DATA) begin
                r_nib_phase <= 1'b0;
                r_hold_vld  <= 1'b0;
                r_len       <= '0;
                r_err_seen  <= 1'b0;
            end else if (gmii_rx_dv) begin
                r_err_seen <= r_err_seen | gmii_rx_er;
                if (r_nib_mode) begin
                    r_nib_phase <= ~r_nib_phase;
                    if (!r_nib_phase) r_nib_lo <= gmii_rxd[3:0];
                end
                if (w_byte_done) begin
                    r_hold     <= w_byte;
                    r_hold_vld <= 1'b1;
                    r_len      <= r_len + LEN_W'(1);
                end
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_last    = r_rx_last;
    assign rx_err     = r_rx_err;
    assign frames_ok  = r_frames_ok;
    assign frames_bad = r_frames_bad;

endmodule
